// File: rtl/reg_bank_pkg.sv
// Shared constants for the configuration/status register bank: reset values and read latencies.
package reg_bank_pkg;

    localparam int unsigned LAT_1     = 1;
    localparam int unsigned LAT_2     = 2;
    localparam int unsigned RST_VAL_W = 64;

    localparam logic [7:0] REG2_RST = 8'h81;  // parity enable, prescale 32
    localparam logic [7:0] REG3_RST = 8'h20;

    // Reset value of register `index`, truncated to `width` bits.
    function automatic logic [RST_VAL_W-1:0] rst_val(input int unsigned index,
                                                     input int unsigned width);
        logic [RST_VAL_W-1:0] val;
        logic [RST_VAL_W-1:0] msk;
        val = '0;
        if (index == 2) begin
            val = RST_VAL_W'(REG2_RST);
        end else if (index == 3) begin
            val = RST_VAL_W'(REG3_RST);
        end
        msk = (width >= RST_VAL_W) ? '1 : ((RST_VAL_W'(1) << width) - RST_VAL_W'(1));
        return val & msk;
    endfunction

endpackage

// File: rtl/reg_bank_param_rd_pipe.sv
// Read-response pipeline of DEPTH stages carrying {valid, err, data}; data holds between reads.
module rd_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic                  err_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      err_q;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    // Flags shift every cycle; data only advances alongside a valid beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            err_q[0]   <= err_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign err_o   = err_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised config/status register bank with bus and hardware write ports and exported low registers.
module reg_bank_param
    import reg_bank_pkg::*;
#(
    parameter int unsigned     DATA_WIDTH = 8,
    parameter int unsigned     ADDR_WIDTH = 4,
    parameter int unsigned     DEPTH      = 16,
    parameter int unsigned     NUM_EXPORT = 4,
    parameter logic [DEPTH-1:0] RO_MASK   = '0,
    parameter int unsigned     RD_LATENCY = LAT_1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             WrEn,
    input  logic                             RdEn,
    input  logic [ADDR_WIDTH-1:0]            Address,
    input  logic [DATA_WIDTH-1:0]            WrData,
    input  logic [DATA_WIDTH-1:0]            WrMask,
    input  logic                             HwWrEn,
    input  logic [ADDR_WIDTH-1:0]            HwAddr,
    input  logic [DATA_WIDTH-1:0]            HwWrData,
    output logic [DATA_WIDTH-1:0]            RdData,
    output logic                             RdData_valid,
    output logic                             Err,
    output logic                             HwCollision,
    output logic [NUM_EXPORT*DATA_WIDTH-1:0] REG_OUT
);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      bus_sel;
    logic [DEPTH-1:0]      hw_sel;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  bus_mapped;
    logic                  hw_mapped;
    logic                  wr_ok;
    logic                  wr_err_d, wr_err_q;
    logic                  coll_d, coll_q;
    logic                  rd_req;
    logic                  pipe_err;

    // Address decode and read mux; unmapped addresses select nothing and read as zero.
    always_comb begin
        bus_sel = '0;
        hw_sel  = '0;
        rd_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (Address == ADDR_WIDTH'(i)) begin
                bus_sel[i] = 1'b1;
                rd_word    = regs_q[i];
            end
            if (HwAddr == ADDR_WIDTH'(i)) begin
                hw_sel[i] = 1'b1;
            end
        end
    end

    assign bus_mapped = |bus_sel;
    assign hw_mapped  = |hw_sel;
    assign wr_ok      = WrEn && bus_mapped && !(|(bus_sel & RO_MASK));
    assign wr_err_d   = WrEn && !wr_ok;
    assign coll_d     = wr_ok && HwWrEn && hw_mapped && (Address == HwAddr);
    assign rd_req     = RdEn && !WrEn;

    // Bus write overrides a same-address hardware write; a rejected bus write does not.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (HwWrEn && hw_sel[i]) begin
                regs_d[i] = HwWrData;
            end
            if (wr_ok && bus_sel[i]) begin
                regs_d[i] = (regs_q[i] & ~WrMask) | (WrData & WrMask);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_WIDTH'(rst_val(i, DATA_WIDTH));
            end
            wr_err_q <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_err_q <= wr_err_d;
            coll_q   <= coll_d;
        end
    end

    rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RD_LATENCY)
    ) u_rd_pipe (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .valid_i (rd_req),
        .err_i   (rd_req && !bus_mapped),
        .data_i  (rd_word),
        .valid_o (RdData_valid),
        .err_o   (pipe_err),
        .data_o  (RdData)
    );

    assign Err         = wr_err_q | pipe_err;
    assign HwCollision = coll_q;

    for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
        assign REG_OUT[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench: two register banks (read latency 1 and 2) driven by one stimulus stream.
module tb_reg_bank_param;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WrEn, RdEn, HwWrEn;
    logic [3:0]  Address, HwAddr;
    logic [7:0]  WrData, WrMask, HwWrData;

    logic [7:0]  rd1, rd2;
    logic        v1, v2, e1, e2, c1, c2;
    logic [31:0] ro1, ro2;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    reg_bank_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .NUM_EXPORT(4),
        .RO_MASK(12'h010), .RD_LATENCY(1)
    ) dut1 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
        .WrData(WrData), .WrMask(WrMask), .HwWrEn(HwWrEn), .HwAddr(HwAddr),
        .HwWrData(HwWrData), .RdData(rd1), .RdData_valid(v1), .Err(e1),
        .HwCollision(c1), .REG_OUT(ro1)
    );

    reg_bank_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .NUM_EXPORT(4),
        .RO_MASK(12'h010), .RD_LATENCY(2)
    ) dut2 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
        .WrData(WrData), .WrMask(WrMask), .HwWrEn(HwWrEn), .HwAddr(HwAddr),
        .HwWrData(HwWrData), .RdData(rd2), .RdData_valid(v2), .Err(e2),
        .HwCollision(c2), .REG_OUT(ro2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WrEn   = 1'b0;
        RdEn   = 1'b0;
        HwWrEn = 1'b0;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
        WrEn    = 1'b1;
        Address = a;
        WrData  = d;
        WrMask  = m;
    endtask

    task automatic bus_rd(input logic [3:0] a);
        RdEn    = 1'b1;
        Address = a;
    endtask

    task automatic hw_wr(input logic [3:0] a, input logic [7:0] d);
        HwWrEn   = 1'b1;
        HwAddr   = a;
        HwWrData = d;
    endtask

    initial begin
        RST = 1'b0;
        idle();
        Address = '0; WrData = '0; WrMask = '0; HwAddr = '0; HwWrData = '0;
        tick(); tick();
        RST = 1'b1;

        // reset defaults
        chk("rst_regout1", ro1, 32'h2081_0000);
        chk("rst_regout2", ro2, 32'h2081_0000);
        chk("rst_rd1", {v1, e1, c1, rd1}, 32'h0);
        chk("rst_rd2", {v2, e2, c2, rd2}, 32'h0);

        // masked write to register 1 from A0
        bus_wr(4'd1, 8'hA0, 8'hFF); tick();
        chk("wr_a0", ro1, 32'h2081_A000);
        bus_wr(4'd1, 8'hFF, 8'h0F); tick();
        chk("mask_wr1", ro1, 32'h2081_AF00);
        chk("mask_wr2", ro2, 32'h2081_AF00);
        idle(); bus_rd(4'd1); tick();
        chk("rd_l1_valid", {v1, rd1}, {1'b1, 8'hAF});
        chk("rd_l2_early", v2, 1'b0);
        idle(); tick();
        chk("rd_l1_pulse_hold", {v1, rd1}, {1'b0, 8'hAF});
        chk("rd_l2_valid", {v2, rd2}, {1'b1, 8'hAF});
        tick();
        chk("rd_l2_pulse", v2, 1'b0);

        // read-only register 4
        bus_wr(4'd4, 8'h55, 8'hFF); tick();
        chk("ro_err1", e1, 1'b1);
        chk("ro_err2", e2, 1'b1);
        idle(); tick();
        chk("ro_err_pulse", {e1, e2}, 2'b00);
        bus_rd(4'd4); tick();
        chk("ro_unchanged", {v1, e1, rd1}, {1'b1, 1'b0, 8'h00});
        idle(); hw_wr(4'd4, 8'h33); tick();
        idle(); bus_rd(4'd4); tick();
        chk("ro_hw_rd1", {v1, e1, rd1}, {1'b1, 1'b0, 8'h33});
        idle(); tick();
        chk("ro_hw_rd2", {v2, e2, rd2}, {1'b1, 1'b0, 8'h33});

        // rejected bus write lets the same-address HW write through
        bus_wr(4'd4, 8'h55, 8'hFF); hw_wr(4'd4, 8'h44); tick();
        chk("ro_hw_err_nocoll", {e1, c1}, 2'b10);
        idle(); bus_rd(4'd4); tick();
        chk("ro_hw_through", {v1, rd1}, {1'b1, 8'h44});
        idle(); tick();

        // same-address collision
        bus_wr(4'd5, 8'h11, 8'hFF); hw_wr(4'd5, 8'h22); tick();
        chk("coll_pulse1", {c1, c2, e1}, 3'b110);
        idle(); bus_rd(4'd5); tick();
        chk("coll_once", {c1, c2}, 2'b00);
        chk("coll_bus_wins", {v1, rd1}, {1'b1, 8'h11});
        idle(); tick();

        // different addresses both land
        bus_wr(4'd2, 8'h5A, 8'hFF); hw_wr(4'd3, 8'hC3); tick();
        chk("diff_addr", ro1, 32'hC35A_AF00);
        chk("diff_nocoll", {c1, c2}, 2'b00);
        idle();

        // unmapped read and write
        bus_rd(4'd13); tick();
        chk("unmap_rd1", {v1, e1, rd1}, {1'b1, 1'b1, 8'h00});
        idle(); tick();
        chk("unmap_rd2", {v2, e2, rd2}, {1'b1, 1'b1, 8'h00});
        chk("unmap_rd1_done", {v1, e1}, 2'b00);
        bus_wr(4'd12, 8'hFF, 8'hFF); tick();
        chk("unmap_wr_err", e1, 1'b1);
        idle(); tick();

        // write and read together: write wins, no valid
        bus_wr(4'd1, 8'h3C, 8'hFF); RdEn = 1'b1; tick();
        chk("wr_rd_write", ro1, 32'hC35A_3C00);
        chk("wr_rd_nov1", v1, 1'b0);
        idle(); tick();
        chk("wr_rd_nov2", v2, 1'b0);

        // reset during consecutive reads flushes the pipeline
        bus_rd(4'd1); tick();
        bus_rd(4'd2); tick();
        chk("flush_first", {v2, rd2}, {1'b1, 8'h3C});
        chk("flush_l1", {v1, rd1}, {1'b1, 8'h5A});
        bus_rd(4'd3); #2; RST = 1'b0; #1;
        chk("flush_rst2", {v2, e2, c2, rd2}, 32'h0);
        chk("flush_rst1", {v1, e1, c1, rd1}, 32'h0);
        chk("flush_regout", ro2, 32'h2081_0000);
        idle(); tick(); tick();
        RST = 1'b1;
        tick();
        chk("flush_after1", {v2, e2, rd2}, 32'h0);
        tick();
        chk("flush_after2", {v2, e2, rd2, v1}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_bank_param.md
# reg_bank_param

Parametrised configuration/status register bank: a host-side bus port reads and writes registers, a hardware-side port updates status registers, and the low registers are exported continuously to downstream blocks (ALU operand/config, UART config, clock-divider ratio). Adds over the previous fixed register file:
- configurable depth, data width and export count
- per-bit write mask
- read-only protection
- hardware write port with collision detection
- 1- or 2-cycle read pipeline with single-cycle valid pulse
- error flagging

## Interface
- DATA_WIDTH, 8, register width in bits
- ADDR_WIDTH, 4, bus/HW address width
- DEPTH, 16, implemented registers, 1..2^ADDR_WIDTH; addresses >= DEPTH are unmapped
- NUM_EXPORT, 4, registers 0..NUM_EXPORT-1 driven on REG_OUT, 1..DEPTH
- RO_MASK, 0, DEPTH-bit mask; bit i set = register i not bus-writable
- RD_LATENCY, 1, read latency in cycles, 1 or 2

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- WrEn  in  1  bus write request
- RdEn  in  1  bus read request
- Address  in  ADDR_WIDTH  bus address
- WrData  in  DATA_WIDTH  bus write data
- WrMask  in  DATA_WIDTH  bit write enable; 1 = bit updated
- HwWrEn  in  1  hardware write request
- HwAddr  in  ADDR_WIDTH  hardware write address
- HwWrData  in  DATA_WIDTH  hardware write data, full-word
- RdData  out  DATA_WIDTH  read data, held between reads
- RdData_valid  out  1  one-cycle pulse per accepted read
- Err  out  1  one-cycle pulse, aligned with the request's response cycle
- HwCollision  out  1  one-cycle pulse, cycle after a bus/HW same-address write
- REG_OUT  out  NUM_EXPORT*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Reset values:
  - register 2 = 8'b1000_0001 (parity enable, prescale 32)
  - register 3 = 8'h20
  - all others 0
  - values zero-extended or truncated to DATA_WIDTH
  - RdData = 0, RdData_valid = 0, Err = 0, HwCollision = 0, read pipeline empty
- Bus write (WrEn=1): reg <= (reg & ~WrMask) | (WrData & WrMask).
  - Address >= DEPTH or RO_MASK[Address] set: no update, Err pulses next cycle.
- Bus read (RdEn=1, WrEn=0): samples the register value at the request edge.
  - RdData/RdData_valid appear RD_LATENCY cycles later.
  - Unmapped address: returns 0 with RdData_valid=1 and Err=1.
- WrEn and RdEn together: write performed, read dropped, no valid pulse.
- HW write (HwWrEn=1): full-word update, ignores RO_MASK; unmapped HwAddr ignored silently.
- Bus and HW write to the same mapped address in the same cycle:
  - bus write applied, HW write lost, HwCollision pulses next cycle.
  - A bus write that is rejected (RO) lets the HW write through, no collision.
- Bus and HW write to different addresses in the same cycle: both applied.
- REG_OUT reflects register contents directly, with no extra latency after the write edge.
- Back-to-back reads are accepted every cycle; the pipeline is fully pipelined with no stall.

## Timing
- Write: the register updates at edge N when WrEn is sampled at N.
- Read issued at edge N:
  - RD_LATENCY=1: RdData/RdData_valid valid after edge N+1.
  - RD_LATENCY=2: valid after edge N+2.
- Write at N followed by a read at N+1 to the same address returns the new value.
- A write and a read in flight to the same address: the read returns the value held at its request edge.
- RST asserted mid-read: the pipeline flushes; no valid pulse for in-flight reads after release.
- RST deassertion is expected synchronised upstream; the first request is accepted on the first edge with RST=1.

## Structure
- Package reg_bank_pkg holds:
  - reset-value constants: REG2_RST = 8'h81, REG3_RST = 8'h20
  - function rst_val(index, width)
  - latency constants LAT_1, LAT_2
- Sub-module rd_pipe: carries {valid, err, data}, parametrised depth RD_LATENCY, async-reset to zeros.
- Storage is flop-based; synchronous RAM inference is not used, because REG_OUT needs every export visible at all times.

## Test plan
- Reset release, defaults (DATA_WIDTH=8): REG_OUT register 2 = 8'h81, register 3 = 8'h20, others 0; RdData=0, valid=0.
- Masked write to register 1: WrData=8'hFF, WrMask=8'h0F, starting from 8'hA0. Register becomes 8'hAF. A read at the next cycle returns 8'hAF with a one-cycle valid, at RD_LATENCY 1 and again at 2.
- RO_MASK=16'h0010: write 8'h55 to address 4 leaves the register unchanged and Err pulses. HwWrEn to address 4 with 8'h33 updates it; a read returns 8'h33.
- Same-cycle bus write 8'h11 and HW write 8'h22 to address 5: register = 8'h11, HwCollision pulses once. Different addresses: both land.
- DEPTH=12: a read of address 13 returns 0 with valid=1 and Err=1. WrEn and RdEn together to address 1 write the data and produce no valid pulse.
- Reads issued on 3 consecutive cycles at RD_LATENCY=2, with RST asserted during the third: the first read completes, the rest produce no valid, and all outputs return to reset values.
